instr_encoder: RTL

//  Encoder end of the control unit's opcode/funct interface. Accepts symbolic instruction requests
//  (op class, rs, rt, imm) over valid/ready, packs them into 32-bit words and writes them

---
 rtl/isa_pkg.sv | 43 ++++
 rtl/instr_pack.sv | 28 ++
 rtl/instr_encoder.sv | 117 +++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the control unit and the instruction encoder:
// request op codes, opcode/funct values and R/I word packing helpers.
package isa_pkg;

  localparam int OPC_W = 6;
  localparam int REG_W = 5;
  localparam int FN_W  = 5;
  localparam int IMM_W = 16;

  // Field positions within a 32-bit instruction word
  localparam int OPC_LSB = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int FN_LSB  = 0;
  localparam int IMM_LSB = 0;

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_COMP  = 3'd1;
  localparam logic [2:0] OP_ADDI  = 3'd2;
  localparam logic [2:0] OP_COMPI = 3'd3;
  localparam logic [2:0] OP_AND   = 3'd4;
  localparam logic [2:0] OP_XOR   = 3'd5;

  localparam logic [5:0] OPC_ARITH = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b000001;
  localparam logic [5:0] OPC_COMPI = 6'b000010;
  localparam logic [5:0] OPC_LOGIC = 6'b000011;

  localparam logic [4:0] FN_ADD  = 5'b00000;
  localparam logic [4:0] FN_COMP = 5'b00001;
  localparam logic [4:0] FN_AND  = 5'b00000;
  localparam logic [4:0] FN_XOR  = 5'b00001;

  function automatic logic [31:0] r_word(logic [5:0] opc, logic [4:0] rs, logic [4:0] rt,
                                         logic [4:0] fn);
    return {opc, rs, rt, 11'b0, fn};
  endfunction

  function automatic logic [31:0] i_word(logic [5:0] opc, logic [4:0] rs, logic [15:0] imm);
    return {opc, rs, 5'b0, imm};
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: symbolic op/rs/rt/imm to a 32-bit instruction word,
// flagging op codes outside the defined set.
module instr_pack
  import isa_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (op)
      OP_ADD:   word = r_word(OPC_ARITH, rs, rt, FN_ADD);
      OP_COMP:  word = r_word(OPC_ARITH, rs, rt, FN_COMP);
      OP_ADDI:  word = i_word(OPC_ADDI, rs, imm);
      OP_COMPI: word = i_word(OPC_COMPI, rs, imm);
      OP_AND:   word = r_word(OPC_LOGIC, rs, rt, FN_AND);
      OP_XOR:   word = r_word(OPC_LOGIC, rs, rt, FN_XOR);
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts symbolic requests, writes packed words sequentially
// into imem. Optional running XOR checksum port when INSTR_ENC_CHECKSUM_EN is defined.
module instr_encoder
  import isa_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [15:0]       req_imm,
  input  logic              req_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_illegal,
  output logic              err_overflow,
  output logic [ADDR_W:0]   word_count
`ifdef INSTR_ENC_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ADDR_W+1:0] DEPTH_V  = (ADDR_W+2)'(DEPTH);
  localparam logic [ADDR_W:0]   LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  logic [1:0]        state;
  logic              stage_valid;
  logic              stage_last;
  logic [31:0]       stage_word;
  logic [31:0]       pack_word;
  logic              pack_illegal;
  logic [ADDR_W+1:0] occupancy;
  logic              accept;
  logic              write;

  instr_pack u_pack (
    .op      (req_op),
    .rs      (req_rs),
    .rt      (req_rt),
    .imm     (req_imm),
    .word    (pack_word),
    .illegal (pack_illegal)
  );

  // Words written plus the one staged must stay below DEPTH to accept more
  assign occupancy = {1'b0, word_count} + {{(ADDR_W+1){1'b0}}, stage_valid};
  assign req_ready = (state == S_LOAD) && (occupancy < DEPTH_V);
  assign accept    = req_valid && req_ready && !start;
  assign write     = stage_valid && !start;

  assign imem_we    = write;
  assign imem_addr  = word_count[ADDR_W-1:0];
  assign imem_wdata = stage_word;
  assign busy       = (state == S_LOAD) || stage_valid;
  assign done       = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      stage_valid  <= 1'b0;
      stage_last   <= 1'b0;
      stage_word   <= '0;
      word_count   <= '0;
      err_illegal  <= 1'b0;
      err_overflow <= 1'b0;
    end else if (start) begin
      // Restart drops any staged word and clears progress
      state        <= S_LOAD;
      stage_valid  <= 1'b0;
      word_count   <= '0;
      err_illegal  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      if (write) begin
        stage_valid <= 1'b0;
        word_count  <= word_count + (ADDR_W+1)'(1);
        if (!stage_last && word_count == LAST_IDX) begin
          state        <= S_DONE;
          err_overflow <= 1'b1;
        end
      end
      if (accept) begin
        if (pack_illegal) begin
          err_illegal <= 1'b1;
        end else begin
          stage_valid <= 1'b1;
          stage_last  <= req_last;
          stage_word  <= pack_word;
        end
        if (req_last) state <= S_DONE;
      end
    end
  end

`ifdef INSTR_ENC_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     checksum <= '0;
    else if (start) checksum <= '0;
    else if (write) checksum <= checksum ^ stage_word;
  end
`endif

endmodule
